sdram_wrr_arbiter: RTL
======================

Name: sdram_wrr_arbiter

Overview:
Weighted round-robin arbiter that shares the single SDRAM controller command port between up to seven bus masters. It replaces fixed-priority selection with per-turn credit accounting, where a burst costs more than a single access. An age-based starvation override guarantees that every requester is served within a bounded wait. Read responses are demultiplexed back to the masters by the 3-bit requester ID.

Parameters:
N, 5, number of masters (1..7; ID k+1 identifies master k, ID 0 = idle)
WEIGHT, 4, credits granted to the master holding the round-robin pointer per turn
BURST_COST, 4, credits consumed by a burst grant (single access costs 1)
MAX_WAIT, 16, cycles a requesting master may wait before it is forced to the next grant

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_request  in  N  per-master request
m_ready  out  N  per-master grant, one-hot or zero, same cycle as acceptance
m_write  in  N  1 = write
m_burst  in  N  1 = 64-byte burst
m_address  in  N*26  master k at bits [26k+25:26k]
m_wdata  in  N*32  write data / read tag
m_wstrb  in  N*4  byte strobes
m_rvalid  out  N  read data valid, per master
m_raddress  out  26  broadcast read address
m_rdata  out  32  broadcast read data
m_complete  out  N  burst complete, per master
sdram_request  out  3  registered ID of the accepted master (0 = none)
sdram_ready  in  1  controller accepts a command this cycle
sdram_address  out  26  registered
sdram_write  out  1  registered
sdram_burst  out  1  registered
sdram_wstrb  out  4  registered
sdram_wdata  out  32  registered
sdram_raddress  in  26  read address from the controller
sdram_rdata  in  32  read data
sdram_rvalid  in  3  ID of the read-data recipient (0 = none)
sdram_complete  in  1  burst done

Behaviour:
- Reset (sync, active-high) sets the following; m_ready is forced to 0 while reset is high:
  - sdram_request = 0
  - sdram_address, sdram_write, sdram_burst, sdram_wstrb and sdram_wdata = 0
  - ptr = 0
  - credit = WEIGHT
  - every wait_cnt = 0
- State:
  - ptr, 3 bits: round-robin pointer.
  - credit, clog2(WEIGHT+1) bits: remaining credits of the pointer master.
  - wait_cnt[k], clog2(MAX_WAIT+1) bits per master.
- Grant decision happens only when sdram_ready=1 and any m_request is high.
  - Starved set: masters with m_request[k]=1 and wait_cnt[k]==MAX_WAIT. If the starved set is non-empty, grant its lowest index.
  - Otherwise grant the first requesting master scanning cyclically ptr, ptr+1, …, N-1, 0, ….
- A grant to g sets m_ready[g]=1 combinationally. On the next edge:
  - sdram_request <= g+1.
  - The command fields are registered from master g.
- Credit update, with cost = m_burst[g] ? BURST_COST : 1:
  - Starvation grant: ptr and credit are unchanged.
  - Normal grant with g==ptr: if credit<=cost, set ptr <= (g+1) mod N and credit <= WEIGHT; otherwise credit <= credit-cost.
  - Normal grant with g!=ptr (pointer master idle): apply the g==ptr rule using base = WEIGHT, then set ptr <= g, or g+1 mod N if exhausted.
- sdram_ready=1 with no requests: sdram_request <= 0; other command registers hold.
- sdram_ready=0: every command register holds, no m_ready is asserted, ptr and credit hold.
- wait_cnt[k] update each cycle:
  - Cleared when m_ready[k]=1 or m_request[k]=0.
  - Otherwise incremented, saturating at MAX_WAIT.
- Response path is purely combinational:
  - sdram_rvalid = k+1 with k<N: m_rvalid[k]=1 and m_complete[k]=sdram_complete.
  - Any other ID: all m_rvalid and m_complete are 0.
  - m_raddress and m_rdata always mirror sdram_raddress and sdram_rdata.
- Exactly one grant per sdram_ready cycle.
- A request dropped in the same cycle as sdram_ready is not granted.
- N=1 degenerates to a pass-through, with ptr fixed at 0.

Decomposition:
- Package sdram_pkg holds:
  - SDRAM_ADDR_W=26, SDRAM_DATA_W=32, SDRAM_STRB_W=4, SDRAM_ID_W=3.
  - Typedef sdram_cmd_t {write, burst, address, wstrb, wdata}.
  - Constant SDRAM_ID_NONE=0.
- Sub-module rr_pick: N-bit cyclic find-first from a start index. It returns a valid flag and the index, and is reused for the lowest-index starved pick with start=0.

Test Plan:
1. Reset held 2 cycles with m_request=5'b11111 and sdram_ready=1 -> m_ready=0 and sdram_request=0 throughout; the first post-reset cycle gives m_ready=00001 and sdram_request=1 next cycle.
2. All 5 masters requesting singles, sdram_ready=1 constantly (WEIGHT=4) -> grant order 0,0,0,0,1,1,1,1,2,…,4,4,4,4,0.
3. Masters 0 and 1 requesting bursts (BURST_COST=4) -> grants alternate 0,1,0,1; credit is reloaded each grant.
4. WEIGHT=64, MAX_WAIT=8, m0 requesting singles continuously, m3 raising its request at cycle 10 -> m3 granted at cycle 18; ptr stays 0 and m0 resumes at cycle 19.
5. sdram_ready=0 for 5 cycles with m2 requesting -> no m_ready, sdram_* outputs stable, wait_cnt[2]=5; on ready, m2 is granted.
6. sdram_rvalid=3, sdram_complete=1, sdram_rdata=32'hDEADBEEF -> m_rvalid=00100, m_complete=00100, m_rdata=DEADBEEF; sdram_rvalid=6 or 7 -> m_rvalid=0 and m_complete=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared widths, command record and ID constants for the SDRAM command arbiter.
package sdram_pkg;
    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_STRB_W = 4;
    localparam int SDRAM_ID_W   = 3;

    // ID 0 on the request/rvalid buses means "nobody"; master k is ID k+1.
    localparam logic [SDRAM_ID_W-1:0] SDRAM_ID_NONE = '0;

    typedef struct packed {
        logic                    write;
        logic                    burst;
        logic [SDRAM_ADDR_W-1:0] address;
        logic [SDRAM_STRB_W-1:0] wstrb;
        logic [SDRAM_DATA_W-1:0] wdata;
    } sdram_cmd_t;
endpackage

// File: rtl/sdram_wrr_arbiter_rr_pick.sv
// Cyclic find-first: first set bit of req scanning start, start+1, ..., wrapping at N.
module rr_pick
    import sdram_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]            req,
    input  logic [SDRAM_ID_W-1:0]   start,
    output logic                    valid,
    output logic [SDRAM_ID_W-1:0]   idx
);
    int k;

    // Scan offsets from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(start) + i) % N;
            if (req[k]) begin
                valid = 1'b1;
                idx   = SDRAM_ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/sdram_wrr_arbiter.sv
// Weighted round-robin arbiter in front of the SDRAM controller command port,
// with age-based starvation override and ID-based read response demux.
module sdram_wrr_arbiter
    import sdram_pkg::*;
#(
    parameter int N          = 5,
    parameter int WEIGHT     = 4,
    parameter int BURST_COST = 4,
    parameter int MAX_WAIT   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              m_request,
    output logic [N-1:0]              m_ready,
    input  logic [N-1:0]              m_write,
    input  logic [N-1:0]              m_burst,
    input  logic [N*SDRAM_ADDR_W-1:0] m_address,
    input  logic [N*SDRAM_DATA_W-1:0] m_wdata,
    input  logic [N*SDRAM_STRB_W-1:0] m_wstrb,
    output logic [N-1:0]              m_rvalid,
    output logic [SDRAM_ADDR_W-1:0]   m_raddress,
    output logic [SDRAM_DATA_W-1:0]   m_rdata,
    output logic [N-1:0]              m_complete,
    output logic [SDRAM_ID_W-1:0]     sdram_request,
    input  logic                      sdram_ready,
    output logic [SDRAM_ADDR_W-1:0]   sdram_address,
    output logic                      sdram_write,
    output logic                      sdram_burst,
    output logic [SDRAM_STRB_W-1:0]   sdram_wstrb,
    output logic [SDRAM_DATA_W-1:0]   sdram_wdata,
    input  logic [SDRAM_ADDR_W-1:0]   sdram_raddress,
    input  logic [SDRAM_DATA_W-1:0]   sdram_rdata,
    input  logic [SDRAM_ID_W-1:0]     sdram_rvalid,
    input  logic                      sdram_complete
);
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam int CR_W = $clog2(WEIGHT + 1);
    localparam int CW   = $clog2(WEIGHT + BURST_COST + 1);

    logic [SDRAM_ID_W-1:0]  ptr, ptr_nxt, g, st_idx, rr_idx;
    logic [CR_W-1:0]        credit, credit_nxt;
    logic [CW-1:0]          base, cost;
    logic [N-1:0][WC_W-1:0] wait_cnt;
    logic [N-1:0]           starved;
    logic                   st_vld, rr_vld, grant_en;
    sdram_cmd_t             sel_cmd, cmd_q;

    // Requesters that have waited the full bound jump the queue.
    always_comb begin
        starved = '0;
        for (int k = 0; k < N; k++)
            starved[k] = m_request[k] && (wait_cnt[k] == WC_W'(MAX_WAIT));
    end

    rr_pick #(.N(N)) u_starve (.req(starved),   .start(SDRAM_ID_W'(0)), .valid(st_vld), .idx(st_idx));
    rr_pick #(.N(N)) u_rr     (.req(m_request), .start(ptr),            .valid(rr_vld), .idx(rr_idx));

    // Pick the winner, raise its ready and mux its command fields.
    always_comb begin
        grant_en = sdram_ready && rr_vld && !reset;
        g        = st_vld ? st_idx : rr_idx;
        m_ready  = '0;
        sel_cmd  = '0;
        for (int k = 0; k < N; k++) begin
            if (SDRAM_ID_W'(k) == g) begin
                m_ready[k]      = grant_en;
                sel_cmd.write   = m_write[k];
                sel_cmd.burst   = m_burst[k];
                sel_cmd.address = m_address[k*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                sel_cmd.wstrb   = m_wstrb[k*SDRAM_STRB_W +: SDRAM_STRB_W];
                sel_cmd.wdata   = m_wdata[k*SDRAM_DATA_W +: SDRAM_DATA_W];
            end
        end
    end

    // Credit accounting: a winner other than the pointer master starts from a fresh WEIGHT.
    always_comb begin
        cost = sel_cmd.burst ? CW'(BURST_COST) : CW'(1);
        base = (g == ptr) ? CW'(credit) : CW'(WEIGHT);
        if (base <= cost) begin
            ptr_nxt    = (g == SDRAM_ID_W'(N - 1)) ? '0 : g + SDRAM_ID_W'(1);
            credit_nxt = CR_W'(WEIGHT);
        end else begin
            ptr_nxt    = g;
            credit_nxt = CR_W'(base - cost);
        end
    end

    // Command register, pointer and credit; starvation grants leave the rotation alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdram_request <= SDRAM_ID_NONE;
            cmd_q         <= '0;
            ptr           <= '0;
            credit        <= CR_W'(WEIGHT);
        end else if (grant_en) begin
            sdram_request <= g + SDRAM_ID_W'(1);
            cmd_q         <= sel_cmd;
            if (!st_vld) begin
                ptr    <= ptr_nxt;
                credit <= credit_nxt;
            end
        end else if (sdram_ready) begin
            sdram_request <= SDRAM_ID_NONE;
        end
    end

    // Per-master age: counts cycles spent requesting without a grant, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_ready[k] || !m_request[k])
                    wait_cnt[k] <= '0;
                else if (wait_cnt[k] != WC_W'(MAX_WAIT))
                    wait_cnt[k] <= wait_cnt[k] + WC_W'(1);
            end
        end
    end

    assign sdram_write   = cmd_q.write;
    assign sdram_burst   = cmd_q.burst;
    assign sdram_address = cmd_q.address;
    assign sdram_wstrb   = cmd_q.wstrb;
    assign sdram_wdata   = cmd_q.wdata;

    // Route read valid / burst complete to the master named by the response ID.
    always_comb begin
        m_rvalid   = '0;
        m_complete = '0;
        for (int k = 0; k < N; k++) begin
            m_rvalid[k]   = (sdram_rvalid == SDRAM_ID_W'(k + 1));
            m_complete[k] = (sdram_rvalid == SDRAM_ID_W'(k + 1)) && sdram_complete;
        end
    end

    assign m_raddress = sdram_raddress;
    assign m_rdata    = sdram_rdata;
endmodule
